// File: rtl/mem_wb_pkg.sv
// Shared widths, writeback-select encodings and payload sizing for the MEM/WB stage.
// No logic; imported by the stage top and testbench.
package mem_wb_pkg;

  localparam int XLEN_DEF = 64;
  localparam int RA_W_DEF = 5;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  function automatic int payload_w(input int xlen, input int ra_w);
    return xlen + ra_w + 1;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush; 1-cycle latency when empty.
// in_rdy is registered (skid empty after the edge), so sink back-pressure never reaches the source combinationally.
module pipe_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_vld,
  output logic             o_in_rdy,
  input  logic [WIDTH-1:0] i_in_dat,
  output logic             o_out_vld,
  input  logic             i_out_rdy,
  output logic [WIDTH-1:0] o_out_dat,
  output logic [1:0]       o_occ
);

  logic             r_main_vld;
  logic [WIDTH-1:0] r_main_dat;
  logic             r_skid_vld;
  logic [WIDTH-1:0] r_skid_dat;
  logic             r_in_rdy;
  logic [1:0]       r_occ;

  logic             w_acc;
  logic             w_push;
  logic             w_main_vld_nxt;
  logic [WIDTH-1:0] w_main_dat_nxt;
  logic             w_skid_vld_nxt;
  logic [WIDTH-1:0] w_skid_dat_nxt;

  assign w_acc  = i_in_vld & r_in_rdy;
  assign w_push = r_main_vld & i_out_rdy;

  // An accept implies the skid is empty, so skid->main and input->main never collide.
  always_comb begin
    w_main_vld_nxt = r_main_vld;
    w_main_dat_nxt = r_main_dat;
    w_skid_vld_nxt = r_skid_vld;
    w_skid_dat_nxt = r_skid_dat;
    if (!r_main_vld || w_push) begin
      if (r_skid_vld) begin
        w_main_vld_nxt = 1'b1;
        w_main_dat_nxt = r_skid_dat;
        w_skid_vld_nxt = 1'b0;
      end else if (w_acc) begin
        w_main_vld_nxt = 1'b1;
        w_main_dat_nxt = i_in_dat;
      end else begin
        w_main_vld_nxt = 1'b0;
      end
    end
    if (r_main_vld && !w_push && w_acc) begin
      w_skid_vld_nxt = 1'b1;
      w_skid_dat_nxt = i_in_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_main_vld <= 1'b0;
      r_main_dat <= '0;
      r_skid_vld <= 1'b0;
      r_skid_dat <= '0;
      r_in_rdy   <= 1'b1;
      r_occ      <= 2'd0;
    end else if (i_flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_rdy   <= 1'b1;
      r_occ      <= 2'd0;
    end else begin
      r_main_vld <= w_main_vld_nxt;
      r_main_dat <= w_main_dat_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      r_skid_dat <= w_skid_dat_nxt;
      r_in_rdy   <= ~w_skid_vld_nxt;
      r_occ      <= r_occ + {1'b0, w_acc} - {1'b0, w_push};
    end
  end

  assign o_in_rdy  = r_in_rdy;
  assign o_out_vld = r_main_vld;
  assign o_out_dat = r_main_dat;
  assign o_occ     = r_occ;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB stage: selects writeback data at capture, masks x0 writes, holds beats in a 2-entry skid buffer.
// 1-cycle latency when empty; in_ready registered, drops only when the skid entry is occupied.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int RA_W           = RA_W_DEF,
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] read_data_in,
  input  logic [XLEN-1:0] result_alu_in,
  input  logic [RA_W-1:0] rd_in,
  input  logic            memtoreg_in,
  input  logic            regwrite_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [RA_W-1:0] wb_rd,
  output logic            wb_we,
  output logic [1:0]      occupancy
);

  localparam int PW = payload_w(XLEN, RA_W);

  logic [XLEN-1:0] w_sel_data;
  logic            w_we_in;
  logic [PW-1:0]   w_in_dat;
  logic [PW-1:0]   w_out_dat;
  logic            w_out_vld;

  assign w_sel_data = (memtoreg_in == WB_SEL_MEM) ? read_data_in : result_alu_in;
  assign w_we_in    = regwrite_in & ~(ZERO_HARDWIRED && (rd_in == '0));
  assign w_in_dat   = {w_sel_data, rd_in, w_we_in};

  pipe_skid_buf #(
    .WIDTH(PW)
  ) u_skid (
    .clk       (clk),
    .i_rst_n   (reset),
    .i_flush   (flush),
    .i_in_vld  (in_valid),
    .o_in_rdy  (in_ready),
    .i_in_dat  (w_in_dat),
    .o_out_vld (w_out_vld),
    .i_out_rdy (out_ready),
    .o_out_dat (w_out_dat),
    .o_occ     (occupancy)
  );

  assign out_valid = w_out_vld;
  assign wb_data   = w_out_dat[PW-1 -: XLEN];
  assign wb_rd     = w_out_dat[RA_W:1];
  // Stale we bits of an empty entry must never reach the register file or forwarding match.
  assign wb_we     = w_out_vld & w_out_dat[0];

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Randomized + directed bench for mem_wb_pipe against a queue-based reference model.
module tb_mem_wb_pipe;
  import mem_wb_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic [63:0] read_data_in;
  logic [63:0] result_alu_in;
  logic [4:0]  rd_in;
  logic        memtoreg_in;
  logic        regwrite_in;
  logic        out_ready;

  logic        in_ready,  in_ready0;
  logic        out_valid, out_valid0;
  logic [63:0] wb_data,   wb_data0;
  logic [4:0]  wb_rd,     wb_rd0;
  logic        wb_we,     wb_we0;
  logic [1:0]  occupancy, occupancy0;

  mem_wb_pipe #(.XLEN(64), .RA_W(5), .ZERO_HARDWIRED(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .read_data_in(read_data_in), .result_alu_in(result_alu_in), .rd_in(rd_in),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .out_valid(out_valid),
    .out_ready(out_ready), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .occupancy(occupancy)
  );

  mem_wb_pipe #(.XLEN(64), .RA_W(5), .ZERO_HARDWIRED(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .flush(flush),
    .read_data_in(read_data_in), .result_alu_in(result_alu_in), .rd_in(rd_in),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .out_valid(out_valid0),
    .out_ready(out_ready), .wb_data(wb_data0), .wb_rd(wb_rd0), .wb_we(wb_we0),
    .occupancy(occupancy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  rd;
    logic        rw;
  } beat_t;

  beat_t       q[$];
  logic [63:0] popped[$];
  bit          known_zero;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit acc, push;
    beat_t b;
    if (!reset) begin
      q.delete();
      known_zero = 1'b1;
    end else begin
      push = (q.size() > 0) && out_ready;
      acc  = in_valid && (q.size() < 2);
      if (push) popped.push_back(q[0].d);
      if (flush) begin
        q.delete();
      end else begin
        if (push) void'(q.pop_front());
        if (acc) begin
          b.d  = memtoreg_in ? read_data_in : result_alu_in;
          b.rd = rd_in;
          b.rw = regwrite_in;
          q.push_back(b);
        end
      end
    end
    if (q.size() > 0) known_zero = 1'b0;
  endtask

  task automatic check_all();
    bit ev;
    ev = q.size() > 0;
    chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
    chk("occupancy", {62'd0, occupancy}, 64'(q.size()));
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("in_ready_zh0", {63'd0, in_ready0}, {63'd0, q.size() < 2});
    if (ev) begin
      chk("wb_data", wb_data, q[0].d);
      chk("wb_rd", {59'd0, wb_rd}, {59'd0, q[0].rd});
      chk("wb_we", {63'd0, wb_we}, {63'd0, q[0].rw && (q[0].rd != 5'd0)});
      chk("wb_data_zh0", wb_data0, q[0].d);
      chk("wb_we_zh0", {63'd0, wb_we0}, {63'd0, q[0].rw});
    end else begin
      chk("wb_we_idle", {63'd0, wb_we}, 64'd0);
      chk("wb_we_idle_zh0", {63'd0, wb_we0}, 64'd0);
      if (known_zero) begin
        chk("wb_data_rst", wb_data, 64'd0);
        chk("wb_rd_rst", {59'd0, wb_rd}, 64'd0);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [63:0] alu, input logic [63:0] mem,
                       input logic [4:0] rd, input logic mtr, input logic rw);
    in_valid      = v;
    result_alu_in = alu;
    read_data_in  = mem;
    rd_in         = rd;
    memtoreg_in   = mtr;
    regwrite_in   = rw;
  endtask

  // Toggle out_ready/in_valid mid-cycle: a registered in_ready must not move.
  task automatic comb_chk();
    logic r0;
    r0 = in_ready;
    out_ready = ~out_ready;
    in_valid  = ~in_valid;
    #1;
    chk("in_ready_comb", {63'd0, in_ready}, {63'd0, r0});
    out_ready = ~out_ready;
    in_valid  = ~in_valid;
    #1;
  endtask

  initial begin
    beat_t bp[4];
    int    idx;
    bit    seen_full;
    total = 0;
    bad   = 0;
    known_zero = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b0;
    drive(1'b1, 64'h55, 64'h66, 5'd7, 1'b0, 1'b1);

    // Reset held with a beat offered: nothing captured.
    cycle();
    cycle();
    reset = 1'b1;
    drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
    cycle();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Back-to-back ALU then MEM beat.
    drive(1'b1, 64'h10, 64'hFFFF, 5'd3, WB_SEL_ALU, 1'b1);
    cycle();
    chk("stream_a_data", wb_data, 64'h10);
    chk("stream_a_rd", {59'd0, wb_rd}, 64'd3);
    drive(1'b1, 64'h1234, 64'hDEADBEEF, 5'd4, WB_SEL_MEM, 1'b1);
    cycle();
    chk("stream_b_data", wb_data, 64'hDEADBEEF);
    chk("stream_b_rd", {59'd0, wb_rd}, 64'd4);

    // Write to x0.
    drive(1'b1, 64'hABC, 64'h0, 5'd0, WB_SEL_ALU, 1'b1);
    cycle();
    chk("x0_valid", {63'd0, out_valid}, 64'd1);
    chk("x0_we_masked", {63'd0, wb_we}, 64'd0);
    chk("x0_we_unmasked", {63'd0, wb_we0}, 64'd1);
    drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
    cycle();

    // Back-pressure: A..D with out_ready low on cycles 2-4.
    popped.delete();
    for (int i = 0; i < 4; i++) begin
      bp[i].d  = 64'hA0 + 64'(i);
      bp[i].rd = 5'(i + 1);
      bp[i].rw = 1'b1;
    end
    idx = 0;
    seen_full = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      bit will_acc;
      out_ready = !(cyc >= 2 && cyc <= 4);
      if (idx < 4) drive(1'b1, bp[idx].d, 64'h0, bp[idx].rd, WB_SEL_ALU, bp[idx].rw);
      else         drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
      will_acc = in_valid && (q.size() < 2);
      comb_chk();
      cycle();
      if (will_acc) idx++;
      if (occupancy == 2'd2 && !in_ready) seen_full = 1'b1;
    end
    chk("bp_full_seen", {63'd0, seen_full}, 64'd1);
    chk("bp_count", 64'(popped.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < popped.size()) chk("bp_order", popped[i], 64'hA0 + 64'(i));

    // Flush with two held beats and a beat offered the same cycle.
    out_ready = 1'b0;
    drive(1'b1, 64'h111, 64'h0, 5'd9, WB_SEL_ALU, 1'b1);
    cycle();
    drive(1'b1, 64'h222, 64'h0, 5'd10, WB_SEL_ALU, 1'b1);
    cycle();
    chk("pre_flush_occ", {62'd0, occupancy}, 64'd2);
    flush = 1'b1;
    drive(1'b1, 64'h333, 64'h0, 5'd11, WB_SEL_ALU, 1'b1);
    cycle();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_occ", {62'd0, occupancy}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
    cycle();
    cycle();

    // Accept and push together at occupancy 1.
    out_ready = 1'b0;
    drive(1'b1, 64'h444, 64'h0, 5'd12, WB_SEL_ALU, 1'b1);
    cycle();
    out_ready = 1'b1;
    drive(1'b1, 64'h0, 64'h555, 5'd13, WB_SEL_MEM, 1'b1);
    cycle();
    chk("accpush_occ", {62'd0, occupancy}, 64'd1);
    chk("accpush_head", wb_data, 64'h555);
    chk("accpush_in_ready", {63'd0, in_ready}, 64'd1);

    // Random traffic with occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 59) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (n % 7 == 0) comb_chk();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
